song_sequencer: RTL and testbench
=================================

SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 play  input  1  level; 1 = advance through song, 0 = hold (pause).
REQ-004 beat_tick  input  1  one-cycle pulse per duration unit from the tempo divider.
REQ-005 skip_fwd  input  1  one-cycle pulse (pre-debounced); jump to next entry.
REQ-006 skip_back  input  1  one-cycle pulse (pre-debounced); jump to previous entry.
REQ-007 rom_addr  output  6  address to the synchronous song ROM.
REQ-008 rom_data  input  16  ROM word, valid one cycle after rom_addr; [15] end marker, [14:9] note, [8:0] duration in beat_ticks.
REQ-009 current_addr  output  6  address of the entry now sounding; drives the note display.
REQ-010 note  output  6  note code of the current entry.
REQ-011 note_start  output  1  one-cycle pulse when a new note begins.
REQ-012 playing  output  1  1 while in PLAY and play=1.
REQ-013 song_done  output  1  level; 1 in DONE.

Function
REQ-014 States: IDLE, FETCH, LOAD, PLAY, DONE.
REQ-015 IDLE: all counters held; play=1 -> FETCH with rom_addr=current_addr.
REQ-016 FETCH: exactly one cycle; rom_addr held; -> LOAD.
REQ-017 LOAD: capture rom_data; [15]=1 -> DONE; duration=0 -> current_addr+1, FETCH, no note_start; else note<=[14:9], dur_cnt<=[8:0], note_start=1 that cycle, -> PLAY.
REQ-018 PLAY: dur_cnt decrements on beat_tick only while play=1; on beat_tick with dur_cnt=1 -> current_addr+1, FETCH.
REQ-019 beat_tick in FETCH/LOAD/IDLE/DONE is ignored (not queued).
REQ-020 play=0 in PLAY freezes dur_cnt, note, current_addr; play=1 resumes with no new note_start.
REQ-021 skip_fwd in PLAY, IDLE or LOAD: current_addr+1, -> FETCH; in FETCH: ignored.
REQ-022 skip_back in PLAY, IDLE or LOAD: current_addr-1 (held at 0 when already 0), -> FETCH; in FETCH: ignored.
REQ-023 skip_fwd and skip_back same cycle: both ignored.
REQ-024 Skip and terminal beat_tick same cycle: skip wins; single address change.
REQ-025 current_addr arithmetic is 6-bit modulo 64; 63+1 -> 0.
REQ-026 rom_addr equals current_addr in every state.
REQ-027 DONE: outputs held; skip_back -> current_addr-1, FETCH; other inputs ignored.
REQ-028 note_start latency: exactly 2 cycles after entry to FETCH.

Reset
REQ-029 rst_n=0 forces IDLE immediately, asynchronously, including mid-note or mid-fetch.
REQ-030 Reset values: current_addr=0, rom_addr=0, note=0, dur_cnt=0, note_start=0, playing=0, song_done=0.
REQ-031 First note after reset release requires play=1; no note_start before.

Configuration
REQ-032 Macro SONG_SEQUENCER_LOOP_EN.
REQ-033 Defined: LOAD with [15]=1 sets current_addr=0, -> FETCH; song_done pulses 1 cycle; DONE unreachable.
REQ-034 Undefined: LOAD with [15]=1 -> DONE, song_done held 1 until reset or skip_back.

Verification
REQ-035 ROM {0:note5 dur3, 1:note9 dur1, 2:end}; play=1, beat_tick every 4 cycles -> note_start at addr0 (note=5), addr1 after 3 ticks (note=9), then song_done=1 (loop off).
REQ-036 In PLAY dur=5, play=0 after 2 ticks, 10 ticks supplied, play=1 -> 3 more ticks to advance; no extra note_start.
REQ-037 current_addr=0, skip_back -> stays 0, FETCH, note_start 2 cycles later; current_addr=63, skip_fwd -> 0.
REQ-038 skip_fwd and terminal beat_tick same cycle at addr 4 -> current_addr=5, one note_start.
REQ-039 rst_n low during LOAD -> all outputs 0 same cycle, no note_start after release until play=1.
REQ-040 LOOP_EN defined, end marker at addr 2 -> song_done 1-cycle pulse, note_start at addr 0 again.

Source files
------------

// File: rtl/song_sequencer.sv
// Song ROM sequencer: fetches one entry per note and holds it for its duration in beat_ticks.
// Optional feature macro SONG_SEQUENCER_LOOP_EN: the end marker wraps playback to address 0 instead of stopping.
module song_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        play,
  input  logic        beat_tick,
  input  logic        skip_fwd,
  input  logic        skip_back,
  output logic [5:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic [5:0]  current_addr,
  output logic [5:0]  note,
  output logic        note_start,
  output logic        playing,
  output logic        song_done
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_DONE} state_t;

  state_t     state, state_nxt;
  logic [8:0] dur_cnt;
  logic       fwd, back;
  logic       addr_inc, addr_dec, addr_clr, load_note, dur_dec;
`ifdef SONG_SEQUENCER_LOOP_EN
  logic       done_pulse;
`endif

  // Simultaneous skips cancel each other out.
  assign fwd  = skip_fwd & ~skip_back;
  assign back = skip_back & ~skip_fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    addr_inc  = 1'b0;
    addr_dec  = 1'b0;
    addr_clr  = 1'b0;
    load_note = 1'b0;
    dur_dec   = 1'b0;
    case (state)
      S_IDLE: begin
        if (fwd) begin
          addr_inc  = 1'b1;
          state_nxt = S_FETCH;
        end else if (back) begin
          addr_dec  = 1'b1;
          state_nxt = S_FETCH;
        end else if (play) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD: begin
        if (fwd) begin
          addr_inc  = 1'b1;
          state_nxt = S_FETCH;
        end else if (back) begin
          addr_dec  = 1'b1;
          state_nxt = S_FETCH;
        end else if (rom_data[15]) begin
`ifdef SONG_SEQUENCER_LOOP_EN
          addr_clr  = 1'b1;
          state_nxt = S_FETCH;
`else
          state_nxt = S_DONE;
`endif
        end else if (rom_data[8:0] == 9'd0) begin
          addr_inc  = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          load_note = 1'b1;
          state_nxt = S_PLAY;
        end
      end
      S_PLAY: begin
        // A skip takes priority over a terminal beat so the address moves only once.
        if (fwd) begin
          addr_inc  = 1'b1;
          state_nxt = S_FETCH;
        end else if (back) begin
          addr_dec  = 1'b1;
          state_nxt = S_FETCH;
        end else if (play && beat_tick) begin
          if (dur_cnt == 9'd1) begin
            addr_inc  = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            dur_dec = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (back) begin
          addr_dec  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rom_addr = current_addr;
    playing  = (state == S_PLAY) && play;
`ifdef SONG_SEQUENCER_LOOP_EN
    song_done = done_pulse;
`else
    song_done = (state == S_DONE);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      current_addr <= 6'd0;
      note         <= 6'd0;
      dur_cnt      <= 9'd0;
      note_start   <= 1'b0;
    end else begin
      note_start <= load_note;
      if (addr_clr)
        current_addr <= 6'd0;
      else if (addr_inc)
        current_addr <= current_addr + 6'd1;
      else if (addr_dec && current_addr != 6'd0)
        current_addr <= current_addr - 6'd1;
      if (load_note) begin
        note    <= rom_data[14:9];
        dur_cnt <= rom_data[8:0];
      end else if (dur_dec) begin
        dur_cnt <= dur_cnt - 9'd1;
      end
    end
  end

`ifdef SONG_SEQUENCER_LOOP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_pulse <= 1'b0;
    else        done_pulse <= addr_clr;
  end
`endif

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: a vector table for the basic song plus hand-written corner sequences.
module tb_song_sequencer;

  logic        clk, rst_n, play, beat_tick, skip_fwd, skip_back;
  logic [5:0]  rom_addr, current_addr, note;
  logic [15:0] rom_data;
  logic        note_start, playing, song_done;
  logic [15:0] rom [64];

  int checks = 0;
  int errors = 0;
  int ns_cnt = 0;

  typedef struct packed {
    logic       p;
    logic       t;
    logic [5:0] addr;
    logic [5:0] note;
    logic       ns;
    logic       pl;
    logic       dn;
  } vec_t;

  vec_t tbl[$];

  song_sequencer dut (
    .clk(clk), .rst_n(rst_n), .play(play), .beat_tick(beat_tick),
    .skip_fwd(skip_fwd), .skip_back(skip_back), .rom_addr(rom_addr),
    .rom_data(rom_data), .current_addr(current_addr), .note(note),
    .note_start(note_start), .playing(playing), .song_done(song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic vec_t mk(input int p, t, a, n, ns, pl, dn);
    vec_t v;
    v.p = (p != 0); v.t = (t != 0);
    v.addr = a[5:0]; v.note = n[5:0];
    v.ns = (ns != 0); v.pl = (pl != 0); v.dn = (dn != 0);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int p, t, f, b);
    @(negedge clk);
    play = (p != 0); beat_tick = (t != 0); skip_fwd = (f != 0); skip_back = (b != 0);
    #1;
    if (note_start) ns_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; play = 1'b0; beat_tick = 1'b0; skip_fwd = 1'b0; skip_back = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Leaves the sequencer in FETCH at the target address, reached by repeated skip_fwd from reset.
  task automatic goto_addr(input logic [5:0] tgt);
    do_reset();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (current_addr == tgt) break;
      skip_fwd = 1'b1;
    end
    skip_fwd = 1'b0;
    check("goto_addr", 32'(current_addr), 32'(tgt));
    ns_cnt = 0;
  endtask

  initial begin
    rst_n = 1'b0; play = 1'b0; beat_tick = 1'b0; skip_fwd = 1'b0; skip_back = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = {1'b0, i[5:0], 9'd2};
    rom[0] = {1'b0, 6'd5, 9'd3};
    rom[1] = {1'b0, 6'd9, 9'd1};
    rom[2] = 16'h8000;
    rom[3] = {1'b0, 6'd7, 9'd0};
    rom[4] = {1'b0, 6'd12, 9'd1};
    rom[5] = {1'b0, 6'd13, 9'd5};

    // {play, tick, addr, note, note_start, playing, song_done}, beat_tick every 4 cycles
    tbl.push_back(mk(1,0, 0,0, 0,0,0));
    tbl.push_back(mk(1,0, 0,0, 0,0,0));
    tbl.push_back(mk(1,1, 0,0, 0,0,0));
    tbl.push_back(mk(1,0, 0,5, 1,1,0));
    tbl.push_back(mk(1,0, 0,5, 0,1,0));
    tbl.push_back(mk(1,0, 0,5, 0,1,0));
    tbl.push_back(mk(1,1, 0,5, 0,1,0));
    tbl.push_back(mk(1,0, 0,5, 0,1,0));
    tbl.push_back(mk(1,0, 0,5, 0,1,0));
    tbl.push_back(mk(1,0, 0,5, 0,1,0));
    tbl.push_back(mk(1,1, 0,5, 0,1,0));
    tbl.push_back(mk(1,0, 0,5, 0,1,0));
    tbl.push_back(mk(1,0, 0,5, 0,1,0));
    tbl.push_back(mk(1,0, 0,5, 0,1,0));
    tbl.push_back(mk(1,1, 0,5, 0,1,0));
    tbl.push_back(mk(1,0, 1,5, 0,0,0));
    tbl.push_back(mk(1,0, 1,5, 0,0,0));
    tbl.push_back(mk(1,0, 1,9, 1,1,0));
    tbl.push_back(mk(1,1, 1,9, 0,1,0));
    tbl.push_back(mk(1,0, 2,9, 0,0,0));
    tbl.push_back(mk(1,0, 2,9, 0,0,0));

    #2;
    check("reset_outputs", 32'({rom_addr, current_addr, note, note_start, playing, song_done}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].p, tbl[i].t, 0, 0);
      check($sformatf("vec%0d", i),
            32'({rom_addr, current_addr, note, note_start, playing, song_done}),
            32'({tbl[i].addr, tbl[i].addr, tbl[i].note, tbl[i].ns, tbl[i].pl, tbl[i].dn}));
    end

`ifdef SONG_SEQUENCER_LOOP_EN
    cyc(1, 0, 0, 0);
    check("loop_done_pulse", 32'({current_addr, song_done}), 32'({6'd0, 1'b1}));
    cyc(1, 0, 0, 0);
    check("loop_done_clear", 32'(song_done), 32'd0);
    cyc(1, 0, 0, 0);
    check("loop_restart", 32'({current_addr, note, note_start}), 32'({6'd0, 6'd5, 1'b1}));
`else
    cyc(1, 1, 0, 0);
    check("done_state", 32'({current_addr, note, playing, song_done}), 32'({6'd2, 6'd9, 1'b0, 1'b1}));
    cyc(1, 0, 1, 0);
    check("done_ignores_fwd", 32'({current_addr, song_done}), 32'({6'd2, 1'b1}));
    cyc(1, 0, 0, 1);
    check("done_hold", 32'(song_done), 32'd1);
    cyc(1, 0, 0, 0);
    check("done_skip_back", 32'({current_addr, song_done}), 32'({6'd1, 1'b0}));
`endif

    // Skip and terminal beat in the same cycle at address 4.
    goto_addr(6'd4);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    check("addr4_note", 32'({note, note_start}), 32'({6'd12, 1'b1}));
    ns_cnt = 0;
    repeat (4) cyc(1, 0, 0, 0);
    check("skip_tick_addr", 32'({current_addr, note}), 32'({6'd5, 6'd13}));
    check("skip_tick_ns_cnt", 32'(ns_cnt), 32'd1);
    cyc(1, 0, 1, 1);
    cyc(1, 0, 0, 0);
    check("both_skips_ignored", 32'({current_addr, playing}), 32'({6'd5, 1'b1}));

    // Asynchronous reset while in LOAD.
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("pre_reset_addr", 32'(current_addr), 32'd6);
    rst_n = 1'b0;
    #1;
    check("reset_in_load", 32'({rom_addr, current_addr, note, note_start, playing, song_done}), 32'd0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ns_cnt = 0;
    repeat (5) cyc(0, 0, 0, 0);
    check("no_note_without_play", 32'({current_addr, 6'(ns_cnt)}), 32'd0);
    repeat (4) cyc(1, 0, 0, 0);
    check("first_note_after_play", 32'({6'(ns_cnt), note, note_start}), 32'({6'd1, 6'd5, 1'b1}));

    // skip_back at address 0 stays at 0; skip_fwd in FETCH is ignored.
    cyc(1, 0, 0, 1);
    cyc(1, 0, 1, 0);
    check("back_at0_fetch", 32'({current_addr, note_start}), 32'd0);
    cyc(1, 0, 0, 0);
    check("back_at0_load", 32'({current_addr, note_start}), 32'd0);
    cyc(1, 0, 0, 0);
    check("back_at0_note", 32'({current_addr, note_start}), 32'({6'd0, 1'b1}));

    // Pause in the middle of a 5-beat note.
    goto_addr(6'd5);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    check("dur5_start", 32'({note, note_start, playing}), 32'({6'd13, 1'b1, 1'b1}));
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    ns_cnt = 0;
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
    check("paused", 32'({current_addr, playing}), 32'({6'd5, 1'b0}));
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    check("resumed_playing", 32'(playing), 32'd1);
    cyc(1, 1, 0, 0);
    check("resume_2_ticks", 32'(current_addr), 32'd5);
    cyc(1, 0, 0, 0);
    check("resume_3_ticks", 32'(current_addr), 32'd6);
    check("pause_no_ns", 32'(ns_cnt), 32'd0);

    // Zero-duration entry is passed over without a note_start.
    goto_addr(6'd3);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("dur0_skipped", 32'({current_addr, 6'(ns_cnt)}), 32'({6'd4, 6'd0}));

    // Address wraps from 63 to 0.
    goto_addr(6'd63);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    check("at63", 32'(current_addr), 32'd63);
    cyc(0, 0, 0, 0);
    check("wrap63", 32'({current_addr, rom_addr}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
